// File: rtl/param_sample_fifo.sv
// Parametrised synchronous sample FIFO for buffering DWT lifting coefficients.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module param_sample_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 1,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic OW_EN = (OVERWRITE != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;
  logic             drop;
  logic             rd_adv;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A full FIFO is never empty, so rd_en alongside a full write always frees a slot.
  always_comb begin
    do_rd  = rd_en & ~empty & ~flush;
    do_wr  = wr_en & ~flush & (~full | rd_en | OW_EN);
    drop   = wr_en & ~flush & full & ~rd_en & OW_EN;
    rd_adv = do_rd | drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_rd)
        data_out <= mem[rd_ptr];
      case ({do_wr, rd_adv})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic udf_set;

  // Flush suppresses the request, so it can neither overflow nor underflow.
  assign ovf_set = wr_en & full & ~rd_en & ~flush;
  assign udf_set = rd_en & empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~err_clr) | ovf_set;
      underflow <= (underflow & ~err_clr) | udf_set;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
